// File: rtl/dbg_cmd_sched.sv
// Command scheduler that accepts one host command stream and issues each command to one dbg_guv,
// or to every guv in turn for a broadcast. Each output handshake is bounded by a timeout.
module dbg_cmd_sched #(
  parameter int NUM_GUV    = 5,
  parameter int ADDR_WIDTH = 3,
  parameter int TIMEOUT    = 255,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLOCK_50,
  input  logic                  rst,
  input  logic [31:0]           cmd_in_TDATA,
  input  logic                  cmd_in_TVALID,
  output logic                  cmd_in_TREADY,
  output logic [31:0]           cmd_out_TDATA,
  output logic [NUM_GUV-1:0]    cmd_out_TVALID,
  input  logic [NUM_GUV-1:0]    cmd_out_TREADY,
  input  logic                  err_clr,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  err_badaddr,
  output logic [ADDR_WIDTH-1:0] last_target,
  output logic [CNT_WIDTH-1:0]  done_cnt
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_NEXT} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_idx, w_idx_nxt;
  logic                  r_bcast, w_bcast_nxt;
  logic [WAIT_W-1:0]     r_wait;
  logic                  r_in_tready, w_in_tready_nxt;
  logic [NUM_GUV-1:0]    r_out_tvalid, w_out_tvalid_nxt;
  logic                  r_busy, w_busy_nxt;
  logic [31:0]           r_tdata;
  logic                  r_err_timeout, r_err_badaddr;
  logic [ADDR_WIDTH-1:0] r_last_target;
  logic [CNT_WIDTH-1:0]  r_done_cnt;

  logic [ADDR_WIDTH-1:0] w_tgt;
  logic                  w_accept, w_tgt_ok, w_tgt_bc, w_hs, w_expire;

  assign w_tgt    = cmd_in_TDATA[31 -: ADDR_WIDTH];
  assign w_accept = (r_state == S_IDLE) && cmd_in_TVALID && r_in_tready;
  assign w_tgt_ok = (w_tgt < ADDR_WIDTH'(NUM_GUV));
  assign w_tgt_bc = &w_tgt;
  // The registered valid is one-hot on r_idx, so masking with it ignores unselected readies.
  assign w_hs     = (r_state == S_ISSUE) && ((cmd_out_TREADY & r_out_tvalid) != '0);
  assign w_expire = (r_state == S_ISSUE) && !w_hs && (r_wait == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_bcast       <= 1'b0;
      r_wait        <= '0;
      r_in_tready   <= 1'b0;
      r_out_tvalid  <= '0;
      r_busy        <= 1'b0;
      r_tdata       <= '0;
      r_err_timeout <= 1'b0;
      r_err_badaddr <= 1'b0;
      r_last_target <= '0;
      r_done_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_bcast      <= w_bcast_nxt;
      r_wait       <= (r_state == S_ISSUE && w_state_nxt == S_ISSUE) ? r_wait + WAIT_W'(1) : '0;
      r_in_tready  <= w_in_tready_nxt;
      r_out_tvalid <= w_out_tvalid_nxt;
      r_busy       <= w_busy_nxt;
      if (w_accept && (w_tgt_ok || w_tgt_bc))
        r_tdata <= cmd_in_TDATA;
      if (w_hs) begin
        r_done_cnt    <= r_done_cnt + CNT_WIDTH'(1);
        r_last_target <= r_idx;
      end
      // A new error event in the same cycle as err_clr keeps the flag set.
      r_err_timeout <= w_expire || (r_err_timeout && !err_clr);
      r_err_badaddr <= (w_accept && !w_tgt_ok && !w_tgt_bc) || (r_err_badaddr && !err_clr);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_bcast_nxt = r_bcast;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_tgt_ok) begin
          w_state_nxt = S_ISSUE;
          w_idx_nxt   = w_tgt;
          w_bcast_nxt = 1'b0;
        end else if (w_accept && w_tgt_bc) begin
          w_state_nxt = S_ISSUE;
          w_idx_nxt   = '0;
          w_bcast_nxt = 1'b1;
        end
      end
      S_ISSUE: begin
        if (w_hs || w_expire)
          w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (r_bcast && (r_idx < ADDR_WIDTH'(NUM_GUV - 1))) begin
          w_state_nxt = S_ISSUE;
          w_idx_nxt   = r_idx + ADDR_WIDTH'(1);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_tready_nxt  = (w_state_nxt == S_IDLE);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_out_tvalid_nxt = '0;
    if (w_state_nxt == S_ISSUE)
      w_out_tvalid_nxt = NUM_GUV'(1) << w_idx_nxt;
  end

  assign cmd_in_TREADY  = r_in_tready;
  assign cmd_out_TDATA  = r_tdata;
  assign cmd_out_TVALID = r_out_tvalid;
  assign busy           = r_busy;
  assign err_timeout    = r_err_timeout;
  assign err_badaddr    = r_err_badaddr;
  assign last_target    = r_last_target;
  assign done_cnt       = r_done_cnt;

endmodule

// File: tb/tb_dbg_cmd_sched.sv
// Bench for dbg_cmd_sched: a per-cycle vector table for single, broadcast and bad-address commands,
// then hand sequences for timeout, broadcast with a stuck guv, and reset while waiting.
module tb_dbg_cmd_sched;

  logic        CLOCK_50 = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cmd_in_TDATA = '0;
  logic        cmd_in_TVALID = 1'b0;
  logic [4:0]  cmd_out_TREADY = '0;
  logic        err_clr = 1'b0;

  logic        trdy4, busy4, eto4, eba4;
  logic [31:0] tdata4;
  logic [4:0]  tvalid4;
  logic [2:0]  last4;
  logic [15:0] done4;

  logic        trdy3, busy3, eto3, eba3;
  logic [31:0] tdata3;
  logic [4:0]  tvalid3;
  logic [2:0]  last3;
  logic [15:0] done3;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  dbg_cmd_sched #(.NUM_GUV(5), .ADDR_WIDTH(3), .TIMEOUT(4), .CNT_WIDTH(16)) u_dut4 (
    .CLOCK_50(CLOCK_50), .rst(rst),
    .cmd_in_TDATA(cmd_in_TDATA), .cmd_in_TVALID(cmd_in_TVALID), .cmd_in_TREADY(trdy4),
    .cmd_out_TDATA(tdata4), .cmd_out_TVALID(tvalid4), .cmd_out_TREADY(cmd_out_TREADY),
    .err_clr(err_clr), .busy(busy4), .err_timeout(eto4), .err_badaddr(eba4),
    .last_target(last4), .done_cnt(done4)
  );

  dbg_cmd_sched #(.NUM_GUV(5), .ADDR_WIDTH(3), .TIMEOUT(3), .CNT_WIDTH(16)) u_dut3 (
    .CLOCK_50(CLOCK_50), .rst(rst),
    .cmd_in_TDATA(cmd_in_TDATA), .cmd_in_TVALID(cmd_in_TVALID), .cmd_in_TREADY(trdy3),
    .cmd_out_TDATA(tdata3), .cmd_out_TVALID(tvalid3), .cmd_out_TREADY(cmd_out_TREADY),
    .err_clr(err_clr), .busy(busy3), .err_timeout(eto3), .err_badaddr(eba3),
    .last_target(last3), .done_cnt(done3)
  );

  typedef struct {
    logic        rst, vld;
    logic [31:0] data;
    logic [4:0]  rdy;
    logic        clr;
    logic        e_trdy;
    logic [4:0]  e_tvalid;
    logic        e_busy;
    logic [15:0] e_done;
    logic        e_eto, e_eba;
    logic [2:0]  e_last;
    logic [31:0] e_tdata;
  } vec_t;

  vec_t vq[$];

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic r, input logic v, input logic [31:0] d, input logic [4:0] rd,
                      input logic c, input logic etr, input logic [4:0] etv, input logic eb,
                      input logic [15:0] ed, input logic eto, input logic eba,
                      input logic [2:0] el, input logic [31:0] etd);
    vec_t x;
    x.rst = r; x.vld = v; x.data = d; x.rdy = rd; x.clr = c;
    x.e_trdy = etr; x.e_tvalid = etv; x.e_busy = eb; x.e_done = ed;
    x.e_eto = eto; x.e_eba = eba; x.e_last = el; x.e_tdata = etd;
    vq.push_back(x);
  endtask

  initial begin
    int cnt1;
    bit done_ok, multihot;
    // rst vld data rdy clr | trdy tvalid busy done eto eba last tdata
    addv(1, 0, 32'h0, 5'h00, 0,  0, 5'h00, 0, 16'd0, 0, 0, 3'd0, 32'h0);
    addv(0, 0, 32'h0, 5'h00, 0,  1, 5'h00, 0, 16'd0, 0, 0, 3'd0, 32'h0);
    // single command to guv 1
    addv(0, 1, 32'h20000009, 5'h02, 0,  0, 5'h02, 1, 16'd0, 0, 0, 3'd0, 32'h20000009);
    addv(0, 0, 32'h0, 5'h02, 0,  0, 5'h00, 1, 16'd1, 0, 0, 3'd1, 32'h20000009);
    addv(0, 0, 32'h0, 5'h02, 0,  1, 5'h00, 0, 16'd1, 0, 0, 3'd1, 32'h20000009);
    // broadcast, all ready
    addv(0, 1, 32'hE0000002, 5'h1F, 0,  0, 5'h01, 1, 16'd1, 0, 0, 3'd1, 32'hE0000002);
    addv(0, 0, 32'h0, 5'h1F, 0,  0, 5'h00, 1, 16'd2, 0, 0, 3'd0, 32'hE0000002);
    addv(0, 0, 32'h0, 5'h1F, 0,  0, 5'h02, 1, 16'd2, 0, 0, 3'd0, 32'hE0000002);
    addv(0, 0, 32'h0, 5'h1F, 0,  0, 5'h00, 1, 16'd3, 0, 0, 3'd1, 32'hE0000002);
    addv(0, 0, 32'h0, 5'h1F, 0,  0, 5'h04, 1, 16'd3, 0, 0, 3'd1, 32'hE0000002);
    addv(0, 0, 32'h0, 5'h1F, 0,  0, 5'h00, 1, 16'd4, 0, 0, 3'd2, 32'hE0000002);
    addv(0, 0, 32'h0, 5'h1F, 0,  0, 5'h08, 1, 16'd4, 0, 0, 3'd2, 32'hE0000002);
    addv(0, 0, 32'h0, 5'h1F, 0,  0, 5'h00, 1, 16'd5, 0, 0, 3'd3, 32'hE0000002);
    addv(0, 0, 32'h0, 5'h1F, 0,  0, 5'h10, 1, 16'd5, 0, 0, 3'd3, 32'hE0000002);
    addv(0, 0, 32'h0, 5'h1F, 0,  0, 5'h00, 1, 16'd6, 0, 0, 3'd4, 32'hE0000002);
    addv(0, 0, 32'h0, 5'h1F, 0,  1, 5'h00, 0, 16'd6, 0, 0, 3'd4, 32'hE0000002);
    // bad target 6: error, word dropped, still ready, back-to-back accepted
    addv(0, 1, 32'hC0000001, 5'h00, 0,  1, 5'h00, 0, 16'd6, 0, 1, 3'd4, 32'hE0000002);
    addv(0, 1, 32'hC0000001, 5'h00, 0,  1, 5'h00, 0, 16'd6, 0, 1, 3'd4, 32'hE0000002);
    addv(0, 0, 32'h0, 5'h00, 1,  1, 5'h00, 0, 16'd6, 0, 0, 3'd4, 32'hE0000002);
    addv(0, 0, 32'h0, 5'h00, 0,  1, 5'h00, 0, 16'd6, 0, 0, 3'd4, 32'hE0000002);
    // clear and new error in the same cycle: set wins
    addv(0, 1, 32'hC0000001, 5'h00, 1,  1, 5'h00, 0, 16'd6, 0, 1, 3'd4, 32'hE0000002);
    addv(0, 0, 32'h0, 5'h00, 1,  1, 5'h00, 0, 16'd6, 0, 0, 3'd4, 32'hE0000002);

    foreach (vq[i]) begin
      rst = vq[i].rst; cmd_in_TVALID = vq[i].vld; cmd_in_TDATA = vq[i].data;
      cmd_out_TREADY = vq[i].rdy; err_clr = vq[i].clr;
      tick();
      chk($sformatf("vec%0d", i),
          {4'h0, trdy4, tvalid4, busy4, done4, eto4, eba4, last4, tdata4},
          {4'h0, vq[i].e_trdy, vq[i].e_tvalid, vq[i].e_busy, vq[i].e_done,
           vq[i].e_eto, vq[i].e_eba, vq[i].e_last, vq[i].e_tdata});
    end
    cmd_in_TVALID = 0; err_clr = 0; cmd_out_TREADY = '0;

    // timeout on guv 2 with TIMEOUT=4
    cmd_in_TVALID = 1; cmd_in_TDATA = 32'h40000000;
    tick();
    cmd_in_TVALID = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_valid%0d", k), 64'(tvalid4), 64'h04);
      tick();
    end
    chk("to_drop", 64'({tvalid4, eto4, done4}), 64'({5'h00, 1'b1, 16'd6}));
    tick();
    chk("to_idle", 64'({trdy4, busy4}), 64'({1'b1, 1'b0}));
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("to_clr", 64'(eto4), 64'h0);

    // handshake in the expiry cycle is a success
    cmd_in_TVALID = 1; cmd_in_TDATA = 32'h40000000;
    tick();
    cmd_in_TVALID = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("late_valid%0d", k), 64'(tvalid4), 64'h04);
      if (k == 3) cmd_out_TREADY = 5'h04;
      tick();
    end
    chk("late_ok", 64'({tvalid4, eto4, done4, last4}), 64'({5'h00, 1'b0, 16'd7, 3'd2}));
    cmd_out_TREADY = '0;
    tick();
    chk("late_idle", 64'(trdy4), 64'h1);

    // broadcast with guv 1 stuck, TIMEOUT=3
    rst = 1;
    tick();
    rst = 0;
    tick();
    cmd_out_TREADY = 5'b11101;
    cmd_in_TVALID = 1; cmd_in_TDATA = 32'hE0000000;
    tick();
    cmd_in_TVALID = 0;
    cnt1 = 0; done_ok = 0; multihot = 0;
    for (int k = 0; k < 60; k++) begin
      if (tvalid3 == 5'b00010) cnt1++;
      if ($countones(tvalid3) > 1) multihot = 1;
      if (trdy3) begin
        done_ok = 1;
        break;
      end
      tick();
    end
    chk("bc3_finished", 64'(done_ok), 64'h1);
    chk("bc3_onehot", 64'(multihot), 64'h0);
    chk("bc3_guv1_cycles", 64'(cnt1), 64'd3);
    chk("bc3_result", 64'({done3, eto3, last3, busy3}), 64'({16'd4, 1'b1, 3'd4, 1'b0}));
    for (int k = 0; k < 60 && !trdy4; k++) tick();
    chk("bc4_result", 64'({trdy4, done4, eto4}), 64'({1'b1, 16'd4, 1'b1}));

    // reset while guv 3 is waiting
    cmd_out_TREADY = '0;
    cmd_in_TVALID = 1; cmd_in_TDATA = 32'h60000000;
    tick();
    cmd_in_TVALID = 0;
    tick();
    chk("rst_pre", 64'({tvalid4, busy4}), 64'({5'h08, 1'b1}));
    rst = 1;
    tick();
    rst = 0;
    chk("rst_state", 64'({trdy4, tvalid4, busy4, done4, eto4, eba4, last4, tdata4}), 64'h0);
    tick();
    chk("rst_ready", 64'({trdy4, tvalid4, busy4}), 64'({1'b1, 5'h00, 1'b0}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
